// File: rtl/cmt_fsk_tx.sv
// Cassette write-path FSK modulator: frames bytes (start, 8 data LSB first, stop bits)
// into a 1200 Hz space / 2400 Hz mark square wave, with mark carrier between frames.
module cmt_fsk_tx #(
  parameter int HALF_SPACE_CYC = 20833,
  parameter int HALF_MARK_CYC  = 10417,
  parameter int SPACE_HALVES   = 4,
  parameter int MARK_HALVES    = 8,
  parameter int STOP_BITS      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       cmt_out
);

  localparam int MAX_HALF_CYC = (HALF_SPACE_CYC > HALF_MARK_CYC) ? HALF_SPACE_CYC : HALF_MARK_CYC;
  localparam int CNT_W        = (MAX_HALF_CYC > 1) ? $clog2(MAX_HALF_CYC) : 1;
  localparam int MAX_HALVES   = (SPACE_HALVES > MARK_HALVES) ? SPACE_HALVES : MARK_HALVES;
  localparam int HV_W         = (MAX_HALVES > 1) ? $clog2(MAX_HALVES) : 1;

  // Half counter holds cycles remaining in the current half, so loads are N-1.
  localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(HALF_SPACE_CYC - 1);
  localparam logic [CNT_W-1:0] MARK_LOAD  = CNT_W'(HALF_MARK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [HV_W-1:0]  SPACE_LAST = HV_W'(SPACE_HALVES - 1);
  localparam logic [HV_W-1:0]  MARK_LAST  = HV_W'(MARK_HALVES - 1);
  localparam logic [HV_W-1:0]  HV_ZERO    = HV_W'(0);
  localparam logic [HV_W-1:0]  HV_ONE     = HV_W'(1);
  localparam logic [1:0]       STOP_LAST  = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CARRIER = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_STOP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [HV_W-1:0]  halves_q, halves_d;
  logic             cmt_out_q, cmt_out_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;

  logic cur_mark_s, half_end_s, last_half_s, boundary_s;
  logic accept_s, frame_start_s, next_mark_s;

  function automatic logic bit_is_mark(input state_t st, input logic [7:0] sh,
                                       input logic [2:0] idx);
    logic m;
    case (st)
      ST_CARRIER: m = 1'b1;
      ST_STOP:    m = 1'b1;
      ST_START:   m = 1'b0;
      ST_DATA:    m = sh[idx];
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

  // Bit boundary is the last cycle of the final half of the current bit.
  always_comb begin
    cur_mark_s  = bit_is_mark(state_q, shift_q, bit_idx_q);
    half_end_s  = (half_cnt_q == CNT_ZERO);
    last_half_s = cur_mark_s ? (halves_q == MARK_LAST) : (halves_q == SPACE_LAST);
    boundary_s  = (state_q != ST_IDLE) && half_end_s && last_half_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= 3'd0;
      stop_cnt_q  <= 2'd0;
      half_cnt_q  <= CNT_ZERO;
      halves_q    <= HV_ZERO;
      cmt_out_q   <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shift_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      half_cnt_q  <= half_cnt_d;
      halves_q    <= halves_d;
      cmt_out_q   <= cmt_out_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      bit_idx_d  = 3'd0;
      stop_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CARRIER;
        end
        ST_CARRIER: begin
          if (boundary_s && hold_full_q) state_d = ST_START;
          else                           state_d = ST_CARRIER;
        end
        ST_START: begin
          if (boundary_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (boundary_s && (bit_idx_q == 3'd7)) begin
            state_d    = ST_STOP;
            stop_cnt_d = 2'd0;
          end else if (boundary_s) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_STOP: begin
          if (boundary_s && (stop_cnt_q == STOP_LAST)) begin
            state_d    = hold_full_q ? ST_START : ST_CARRIER;
            stop_cnt_d = 2'd0;
          end else if (boundary_s) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: hold/shift handoff and the half-period tone generator.
  always_comb begin
    accept_s      = tx_valid && tx_ready;
    frame_start_s = enable && boundary_s && (state_d == ST_START);
    shift_d       = frame_start_s ? hold_q : shift_q;
    hold_d        = accept_s ? tx_data : hold_q;
    next_mark_s   = bit_is_mark(state_d, shift_d, bit_idx_d);

    if (!enable)            hold_full_d = 1'b0;
    else if (accept_s)      hold_full_d = 1'b1;
    else if (frame_start_s) hold_full_d = 1'b0;
    else                    hold_full_d = hold_full_q;

    if (!enable) begin
      cmt_out_d  = 1'b0;
      half_cnt_d = CNT_ZERO;
      halves_d   = HV_ZERO;
    end else if ((state_q == ST_IDLE) || boundary_s) begin
      // Every bit starts high with a fresh half count in the next bit's tone.
      cmt_out_d  = 1'b1;
      half_cnt_d = next_mark_s ? MARK_LOAD : SPACE_LOAD;
      halves_d   = HV_ZERO;
    end else if (half_end_s) begin
      cmt_out_d  = ~cmt_out_q;
      half_cnt_d = cur_mark_s ? MARK_LOAD : SPACE_LOAD;
      halves_d   = halves_q + HV_ONE;
    end else begin
      cmt_out_d  = cmt_out_q;
      half_cnt_d = half_cnt_q - CNT_ONE;
      halves_d   = halves_q;
    end
  end

  always_comb begin
    tx_ready = enable && !hold_full_q && !reset;
    busy     = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    cmt_out  = cmt_out_q;
  end

endmodule

// File: tb/tb_cmt_fsk_tx.sv
// Scoreboard bench for cmt_fsk_tx: 16-clk bits, 2 stop bits, 176-clk frames.
module tb_cmt_fsk_tx;

  logic       clk = 1'b0;
  logic       reset, enable, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, cmt_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic cmt;
    logic first;
  } exp_t;

  exp_t exp_q[$];
  logic full_m;

  cmt_fsk_tx #(
    .HALF_SPACE_CYC(4),
    .HALF_MARK_CYC (2),
    .SPACE_HALVES  (4),
    .MARK_HALVES   (8),
    .STOP_BITS     (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .cmt_out (cmt_out)
  );

  always #5 clk = ~clk;

  // Expected waveform of one frame: mark = 1100 x4, space = 11110000 x2.
  task automatic push_frame(input logic [7:0] d);
    logic [10:0] bits;
    exp_t        e;
    bits = {2'b11, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        e.cmt   = bits[b] ? (((c / 2) % 2) == 0) : (((c / 4) % 2) == 0);
        e.first = (b == 0) && (c == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmt_out, tx_ready, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_held cmt/ready/busy=%b expected 000", {cmt_out, tx_ready, busy});
    end
    reset = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h81;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({cmt_out, tx_ready, busy} !== 3'b000) begin
        failures++;
        $display("FAIL reset_disabled cyc=%0d cmt/ready/busy=%b expected 000", i, {cmt_out, tx_ready, busy});
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_carrier();
    logic prev, expb;
    int   rises;
    prev = 1'b0;
    enable = 1'b1;
    for (int w = 0; w < 2; w++) begin
      rises = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        expb = (((c / 2) % 2) == 0);
        checks++;
        if (cmt_out !== expb || busy !== 1'b0) begin
          failures++;
          $display("FAIL carrier w=%0d c=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=0", w, c, cmt_out, busy, expb);
        end
        if (cmt_out === 1'b1 && prev === 1'b0) rises++;
        prev = cmt_out;
      end
      checks++;
      if (rises != 4) begin
        failures++;
        $display("FAIL carrier_rises w=%0d got %0d expected 4", w, rises);
      end
    end
  endtask

  task automatic test_single_frame();
    exp_t e;
    int   n, lat;
    logic started, expb;
    repeat ($urandom_range(0, 15)) @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1; full_m = 1'b0;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got %b expected 1", tx_ready);
    end
    @(posedge clk);
    push_frame(8'hA5);
    full_m = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0; lat = -1; started = 1'b0;
    while (exp_q.size() > 0 && n < 600) begin
      if (!started && busy === 1'b1) begin started = 1'b1; lat = n; end
      if (started) begin
        e = exp_q.pop_front();
        checks++;
        if (cmt_out !== e.cmt || busy !== 1'b1) begin
          failures++;
          $display("FAIL single_sample n=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=1", n, cmt_out, busy, e.cmt);
        end
        if (e.first) full_m = 1'b0;
      end
      checks++;
      if (tx_ready !== !full_m) begin
        failures++;
        $display("FAIL single_ready_track n=%0d got %b expected %b", n, tx_ready, !full_m);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || lat < 1 || lat > 16) begin
      failures++;
      $display("FAIL single_latency lat=%0d left=%0d expected lat 1..16 left=0", lat, exp_q.size());
    end
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      expb = (((c / 2) % 2) == 0);
      checks++;
      if (cmt_out !== expb || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_post_carrier c=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=0", c, cmt_out, busy, expb);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n, n_acc;
    logic started, acc, expb;
    repeat ($urandom_range(0, 15)) @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1; full_m = 1'b0;
    @(posedge clk);
    push_frame(8'h00);
    full_m = 1'b1; n_acc = 1;
    @(negedge clk);
    tx_data = 8'hFF;
    n = 0; started = 1'b0; acc = 1'b0;
    while (exp_q.size() > 0 && n < 900) begin
      if (busy === 1'b1) started = 1'b1;
      if (started) begin
        e = exp_q.pop_front();
        checks++;
        if (cmt_out !== e.cmt || busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_sample n=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=1", n, cmt_out, busy, e.cmt);
        end
        if (e.first) full_m = 1'b0;
      end
      checks++;
      if (tx_ready !== !full_m) begin
        failures++;
        $display("FAIL b2b_ready n=%0d got %b expected %b", n, tx_ready, !full_m);
      end
      if (tx_valid && tx_ready === 1'b1) begin
        push_frame(tx_data);
        full_m = 1'b1; n_acc++; acc = 1'b1;
      end
      @(negedge clk);
      if (acc) begin tx_valid = 1'b0; acc = 1'b0; end
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || n_acc != 2) begin
      failures++;
      $display("FAIL b2b_complete accepted=%0d left=%0d expected accepted=2 left=0", n_acc, exp_q.size());
    end
    exp_q.delete();
    tx_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      expb = (((c / 2) % 2) == 0);
      checks++;
      if (cmt_out !== expb || busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_post_carrier c=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=0", c, cmt_out, busy, expb);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int   n;
    logic expb;
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_start busy=%b expected 1", busy);
    end
    repeat (69) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_mid_bit3 busy=%b expected 1", busy);
    end
    enable = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({cmt_out, busy, tx_ready} !== 3'b000) begin
        failures++;
        $display("FAIL abort_off cyc=%0d cmt/busy/ready=%b expected 000", i, {cmt_out, busy, tx_ready});
      end
    end
    tx_valid = 1'b0; enable = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      expb = (((c / 2) % 2) == 0);
      checks++;
      if (cmt_out !== expb || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_reenable c=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=0", c, cmt_out, busy, expb);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int   n;
    logic expb;
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy busy=%b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({cmt_out, busy, tx_ready} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_async cmt/busy/ready=%b expected 000", {cmt_out, busy, tx_ready});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      expb = (((c / 2) % 2) == 0);
      checks++;
      if (cmt_out !== expb || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_carrier c=%0d cmt_out=%b busy=%b expected cmt_out=%b busy=0", c, cmt_out, busy, expb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carrier();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
